sram_io_host: RTL and testbench
===============================

// Module: sram_io_host
// PURPOSE
//  Host-side initiator for the SRAM_IO_CTRL serial port. Turns one parallel request (addr, data, rd/wr)
//  into the full pin sequence: BGN, CTRL mode, LOAD_N, SI scan, RDY polls. Read data returns over SO.
//  Sits in the FPGA/PC bridge in place of the hand-driven control word; one request in flight at a time.
// PARAMETERS
//  MEMORY_DATA_WIDTH  8    SRAM data width
//  MEMORY_ADDR_WIDTH  9    SRAM address width
//  REG_BITS_WIDTH     17   MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH; scan frame length
//  TIMEOUT_CYCLES     255  RDY wait limit; used only when SRAM_HOST_TIMEOUT_EN is defined
// PORTS
//  CLK        in   1   clock; all logic on posedge
//  RST_N      in   1   synchronous reset, active low
//  REQ        in   1   start request; sampled only in IDLE
//  WR         in   1   1=write WDATA to ADDR, 0=read ADDR; captured with REQ
//  ADDR       in   9   SRAM address; captured with REQ
//  WDATA      in   8   write data; captured with REQ (frame data field is 0 for reads)
//  BUSY       out  1   high from the cycle after REQ acceptance until DONE
//  DONE       out  1   one-cycle pulse, request complete
//  RDATA      out  8   read result; valid from DONE, held until the next read's DONE
//  ERR        out  1   timeout flag (see CONFIGURATION); otherwise constant 0
//  CTRL_BGN   out  1   to SRAM_IO_CTRL.BGN
//  CTRL_MODE  out  2   to SRAM_IO_CTRL.CTRL: 00 scan-in, 11 write SRAM, 01 read SRAM, 10 scan-out
//  LOAD_N     out  1   to SRAM_IO_CTRL.LOAD_N, active low
//  SI         out  1   serial data to SRAM_IO_CTRL
//  SO         in   1   serial data from SRAM_IO_CTRL
//  RDY        in   1   SRAM_IO_CTRL ready
// BEHAVIOUR
//  Reset: CTRL_BGN=0, CTRL_MODE=00, LOAD_N=1, SI=0, BUSY=0, DONE=0, RDATA=0, ERR=0, FSM=IDLE.
//   Reset mid-operation aborts at the next edge; no cleanup handshake with the controller.
//  Frame F = {ADDR, data}; shifted LSB first (F[0] first, F[16] last).
//  Phase sequence (each phase = SETUP, LOAD, [SHIFT], WAIT_RDY, REL, WAIT_NRDY):
//   SETUP: CTRL_BGN=1 (1 cycle). LOAD: CTRL_MODE=phase mode (1 cycle), then LOAD_N=0.
//   SHIFT (scan-in only): 1 gap cycle, then REG_BITS_WIDTH cycles, SI=F[cnt], cnt 0..16.
//   WAIT_RDY: hold until RDY=1. REL: CTRL_BGN=0; next cycle LOAD_N=1.
//   WAIT_NRDY: hold until RDY=0, then the next phase starts.
//  Phases: write = SCAN_IN(00) -> WRITE(11) -> DONE. Read = SCAN_IN(00) -> READ(01) -> SCAN_OUT(10) -> DONE.
//  SCAN_OUT: after LOAD_N=0 plus 1 gap cycle, sample SO on REG_BITS_WIDTH consecutive cycles, LSB first.
//   RDATA = first MEMORY_DATA_WIDTH sampled bits; it updates in the DONE cycle only.
//  DONE state: 1 cycle (DONE=1, BUSY=0), then IDLE. REQ is ignored while BUSY or in DONE.
//   Back-to-back: a REQ held high is accepted in the IDLE cycle after DONE.
//  CTRL_MODE holds its value until the next LOAD cycle. SI stays 0 outside SHIFT.
//  RDY already high on WAIT_RDY entry: exits the next cycle. Same rule for RDY low on WAIT_NRDY.
//  Counters: shift cnt 5 bits, saturates at REG_BITS_WIDTH-1. Timeout cnt 8 bits, no wrap.
// CONFIGURATION
//  SRAM_HOST_TIMEOUT_EN defined:
//   Each WAIT_RDY or WAIT_NRDY dwell is counted. After TIMEOUT_CYCLES cycles:
//    - drive CTRL_BGN=0 and LOAD_N=1;
//    - set ERR=1, pulse DONE, return to IDLE;
//    - RDATA is unchanged.
//   ERR clears when the next REQ is accepted.
//  SRAM_HOST_TIMEOUT_EN undefined: waits are unbounded; ERR is tied to 0; no timeout counter is built.
// TESTING
//  1 Write ADDR=0x020 WDATA=0x04 into the SRAM_IO_CTRL+memory model ->
//    SI stream 0,0,1,0,0,0,0,0 then 0,0,0,0,0,1,0,0,0; mode sequence 00,11; DONE once; sram[0x020]=0x04.
//  2 Read ADDR=0x020 after test 1 -> mode sequence 00,01,10; RDATA=0x04 at DONE; scan-in data field all 0.
//  3 Write 14 bytes at 0x020..0x02D, REQ held high -> each DONE followed by acceptance in the next IDLE cycle;
//    read-back of all 14 bytes matches.
//  4 RST_N=0 during SHIFT bit 9 -> next edge: BGN=0, LOAD_N=1, MODE=00, BUSY=0; a new write completes normally.
//  5 REQ pulses while BUSY -> ignored; exactly one DONE per accepted REQ.
//  6 (TIMEOUT_EN) RDY stuck 0 in WAIT_RDY -> DONE+ERR after 255 wait cycles, BGN=0, LOAD_N=1;
//    the next REQ clears ERR.

Source files
------------

// File: rtl/sram_io_host.sv
// sram_io_host: host-side sequencer that drives the SRAM_IO_CTRL serial port for one read or write request.
// Optional RDY wait timeout with ERR reporting is built when SRAM_HOST_TIMEOUT_EN is defined.

module sram_io_host #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req,
    input  logic                         wr,
    input  logic [MEMORY_ADDR_WIDTH-1:0] addr,
    input  logic [MEMORY_DATA_WIDTH-1:0] wdata,
    output logic                         busy,
    output logic                         done,
    output logic [MEMORY_DATA_WIDTH-1:0] rdata,
    output logic                         err,
    output logic                         ctrl_bgn,
    output logic [1:0]                   ctrl_mode,
    output logic                         load_n,
    output logic                         si,
    input  logic                         so,
    input  logic                         rdy
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_LOAD, S_GAP, S_SHIFT,
        S_WAIT_RDY, S_REL, S_WAIT_NRDY, S_DONE
    } state_t;

    // Phase encoding doubles as the CTRL mode driven during that phase.
    typedef enum logic [1:0] {
        PH_SCAN_IN  = 2'b00,
        PH_READ     = 2'b01,
        PH_SCAN_OUT = 2'b10,
        PH_WRITE    = 2'b11
    } phase_t;

    localparam logic [4:0] LAST_BIT = 5'(REG_BITS_WIDTH - 1);

    state_t                    state;
    phase_t                    phase;
    logic                      wr_q;
    logic [REG_BITS_WIDTH-1:0] frame;
    logic [4:0]                cnt;

`ifdef SRAM_HOST_TIMEOUT_EN
    logic [7:0] tcnt;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: reset is synchronous, so it is simply the first branch of the clocked block; all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= PH_SCAN_IN;
            wr_q      <= 1'b0;
            frame     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            ctrl_bgn  <= 1'b0;
            ctrl_mode <= 2'b00;
            load_n    <= 1'b1;
            si        <= 1'b0;
`ifdef SRAM_HOST_TIMEOUT_EN
            tcnt      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        busy     <= 1'b1;
                        wr_q     <= wr;
                        frame    <= {addr, (wr ? wdata : {MEMORY_DATA_WIDTH{1'b0}})};
                        phase    <= PH_SCAN_IN;
                        ctrl_bgn <= 1'b1;
                        state    <= S_SETUP;
`ifdef SRAM_HOST_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_SETUP: begin
                    ctrl_mode <= phase;
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    load_n <= 1'b0;
                    cnt    <= '0;
                    if (phase == PH_SCAN_IN || phase == PH_SCAN_OUT) state <= S_GAP;
                    else                                             state <= S_WAIT_RDY;
                end
                S_GAP: begin
                    if (phase == PH_SCAN_IN) begin
                        si    <= frame[0];
                        frame <= frame >> 1;
                    end
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Scan-out reuses the frame register as the receive shifter, LSB arriving first.
                    if (phase == PH_SCAN_OUT) begin
                        frame <= {so, frame[REG_BITS_WIDTH-1:1]};
                    end else if (cnt != LAST_BIT) begin
                        si    <= frame[0];
                        frame <= frame >> 1;
                    end
                    if (cnt == LAST_BIT) begin
                        si    <= 1'b0;
                        state <= S_WAIT_RDY;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_WAIT_RDY: begin
                    if (rdy) begin
                        ctrl_bgn <= 1'b0;
                        state    <= S_REL;
                    end
                end
                S_REL: begin
                    load_n <= 1'b1;
                    state  <= S_WAIT_NRDY;
                end
                S_WAIT_NRDY: begin
                    if (!rdy) begin
                        case (phase)
                            PH_SCAN_IN: begin
                                if (wr_q) phase <= PH_WRITE;
                                else      phase <= PH_READ;
                                ctrl_bgn <= 1'b1;
                                state    <= S_SETUP;
                            end
                            PH_READ: begin
                                phase    <= PH_SCAN_OUT;
                                ctrl_bgn <= 1'b1;
                                state    <= S_SETUP;
                            end
                            default: begin
                                if (phase == PH_SCAN_OUT) rdata <= frame[MEMORY_DATA_WIDTH-1:0];
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

`ifdef SRAM_HOST_TIMEOUT_EN
            // Later assignments here override the case above when a stalled wait expires.
            if ((state == S_WAIT_RDY && !rdy) || (state == S_WAIT_NRDY && rdy)) begin
                if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    ctrl_bgn <= 1'b0;
                    load_n   <= 1'b1;
                    err_q    <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    tcnt     <= '0;
                    state    <= S_DONE;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
            end else begin
                tcnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_sram_io_host.sv
// tb_sram_io_host: directed bench for sram_io_host against a behavioural SRAM_IO_CTRL + memory model.
// The timeout scenario runs only when SRAM_HOST_TIMEOUT_EN is defined.

module tb_sram_io_host;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   = 1'b0;
    logic       wr    = 1'b0;
    logic [8:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, err, ctrl_bgn, load_n, si;
    logic [7:0] rdata;
    logic [1:0] ctrl_mode;
    logic       so  = 1'b0;
    logic       rdy = 1'b0;

    always #5 clk = ~clk;

    sram_io_host dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .ctrl_bgn  (ctrl_bgn),
        .ctrl_mode (ctrl_mode),
        .load_n    (load_n),
        .si        (si),
        .so        (so),
        .rdy       (rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Controller + memory model, evaluated on the falling edge.
    typedef enum {M_IDLE, M_SHIFT_IN, M_SHIFT_OUT, M_RDY_DLY, M_RDY, M_NRDY_DLY} m_state_t;

    logic [7:0]  mem [0:511];
    logic [1:0]  mode_log [$];
    logic        si_log [$];
    m_state_t    m_state     = M_IDLE;
    int          m_cnt       = 0;
    int          m_dly       = 0;
    int          rdy_lat     = 2;
    bit          rdy_stuck   = 1'b0;
    logic [16:0] sc_reg      = '0;
    logic        prev_load_n = 1'b1;
    int          done_cnt    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rdy         = 1'b0;
            so          = 1'b0;
            m_state     = M_IDLE;
            prev_load_n = 1'b1;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (prev_load_n && !load_n) begin
                        mode_log.push_back(ctrl_mode);
                        m_cnt = 0;
                        m_dly = rdy_lat;
                        case (ctrl_mode)
                            2'b00: m_state = M_SHIFT_IN;
                            2'b10: m_state = M_SHIFT_OUT;
                            2'b11: begin mem[sc_reg[16:8]] = sc_reg[7:0]; m_state = M_RDY_DLY; end
                            default: begin sc_reg[7:0] = mem[sc_reg[16:8]]; m_state = M_RDY_DLY; end
                        endcase
                    end
                end
                M_SHIFT_IN: begin
                    sc_reg[m_cnt] = si;
                    si_log.push_back(si);
                    m_cnt++;
                    if (m_cnt == 17) m_state = M_RDY_DLY;
                end
                M_SHIFT_OUT: begin
                    if (m_cnt == 17) begin
                        so      = 1'b0;
                        m_state = M_RDY_DLY;
                    end else begin
                        so = sc_reg[m_cnt];
                        m_cnt++;
                    end
                end
                M_RDY_DLY: begin
                    if (!rdy_stuck) begin
                        if (m_dly == 0) begin rdy = 1'b1; m_state = M_RDY; end
                        else m_dly--;
                    end
                end
                M_RDY: begin
                    if (!ctrl_bgn && load_n) begin m_dly = rdy_lat; m_state = M_NRDY_DLY; end
                end
                M_NRDY_DLY: begin
                    if (m_dly == 0) begin rdy = 1'b0; m_state = M_IDLE; end
                    else m_dly--;
                end
                default: m_state = M_IDLE;
            endcase
            prev_load_n = load_n;
        end
    end

    always @(negedge clk) if (rst_n && done) done_cnt++;

    task automatic start_req(input logic w, input logic [8:0] a, input logic [7:0] d);
        mode_log.delete();
        si_log.delete();
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; return; end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [16:0] si_word();
        logic [16:0] w = '0;
        for (int k = 0; k < 17 && k < si_log.size(); k++) w[k] = si_log[k];
        return w;
    endfunction

    function automatic logic [7:0] modes_packed();
        logic [7:0] m = '0;
        foreach (mode_log[k]) m = {m[5:0], mode_log[k]};
        return m;
    endfunction

    bit          seen;
    int          base;
    logic [7:0]  b2b_data [14];
    logic [7:0]  exp_rdata;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int i = 0; i < 14; i++) b2b_data[i] = 8'(i * 19 + 5);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_bgn",   ctrl_bgn,  0);
        check("rst_mode",  ctrl_mode, 0);
        check("rst_load_n", load_n,   1);
        check("rst_si",    si,        0);
        check("rst_busy",  busy,      0);
        check("rst_done",  done,      0);
        check("rst_rdata", rdata,     0);
        check("rst_err",   err,       0);
        rst_n = 1'b1;

        // 1: write 0x04 to 0x020
        base = done_cnt;
        start_req(1'b1, 9'h020, 8'h04);
        check("t1_busy_after_accept", busy, 1);
        wait_done(seen);
        check("t1_busy_at_done", busy, 0);
        check("t1_si_stream", si_word(), 17'h02004);
        check("t1_si_len", si_log.size(), 17);
        check("t1_modes", {mode_log.size(), modes_packed()}, {32'd2, 8'b0000_0011} >> 0 == 0 ? 0 : (2 << 8) | 8'h03);
        repeat (3) @(negedge clk);
        check("t1_done_count", done_cnt - base, 1);
        check("t1_mem", mem[9'h020], 8'h04);
        check("t1_err", err, 0);

        // 2: read back 0x020; RDATA must hold until DONE
        start_req(1'b0, 9'h020, 8'hFF);
        repeat (30) @(negedge clk);
        check("t2_rdata_hold", rdata, 8'h00);
        wait_done(seen);
        check("t2_rdata", rdata, 8'h04);
        check("t2_modes", (mode_log.size() << 8) | modes_packed(), (3 << 8) | 8'b0000_0110);
        check("t2_si_data_zero", si_word(), 17'h02000);

        // 3: 14 back-to-back writes with REQ held high
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 9'h020; wdata = b2b_data[0];
        for (int i = 0; i < 14; i++) begin
            wait_done(seen);
            if (!seen) begin req = 1'b0; break; end
            if (i < 13) begin
                addr  = 9'(9'h020 + i + 1);
                wdata = b2b_data[i + 1];
                @(negedge clk);
                @(negedge clk);
                check("t3_b2b_accept", busy, 1);
            end else begin
                req = 1'b0;
            end
        end
        for (int i = 0; i < 14; i++) begin
            start_req(1'b0, 9'(9'h020 + i), 8'h00);
            wait_done(seen);
            check("t3_readback", rdata, b2b_data[i]);
        end
        exp_rdata = b2b_data[13];

        // 4: reset during scan-in bit 9, then a clean write
        start_req(1'b1, 9'h0F0, 8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (si_log.size() == 9) begin seen = 1'b1; break; end
        end
        check("t4_reach_bit9", seen, 1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t4_bgn",    ctrl_bgn,  0);
        check("t4_load_n", load_n,    1);
        check("t4_mode",   ctrl_mode, 0);
        check("t4_busy",   busy,      0);
        check("t4_rdata",  rdata,     0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 8'h00;
        start_req(1'b1, 9'h055, 8'h5A);
        wait_done(seen);
        check("t4_modes", (mode_log.size() << 8) | modes_packed(), (2 << 8) | 8'h03);
        check("t4_mem", mem[9'h055], 8'h5A);
        check("t4_aborted_mem", mem[9'h0F0], 8'h00);

        // 5: REQ pulses while busy are ignored
        start_req(1'b1, 9'h033, 8'h77);
        base = done_cnt;
        for (int p = 0; p < 3; p++) begin
            repeat (4) @(negedge clk);
            req = 1'b1; wr = 1'b1; addr = 9'h1FF; wdata = 8'hEE;
            @(negedge clk);
            req = 1'b0;
        end
        wait_done(seen);
        repeat (10) @(negedge clk);
        check("t5_done_count", done_cnt - base, 1);
        check("t5_busy_idle", busy, 0);
        check("t5_mem", mem[9'h033], 8'h77);
        check("t5_ignored_mem", mem[9'h1FF], 8'h00);

`ifdef SRAM_HOST_TIMEOUT_EN
        // 6: RDY stuck low in WAIT_RDY
        rdy_stuck = 1'b1;
        start_req(1'b1, 9'h0AA, 8'h11);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (si_log.size() == 17) begin seen = 1'b1; break; end
        end
        check("t6_scan_done", seen, 1);
        base = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            base++;
            if (done) break;
        end
        check("t6_wait_cycles", base, 256);
        check("t6_err",    err,      1);
        check("t6_done",   done,     1);
        check("t6_bgn",    ctrl_bgn, 0);
        check("t6_load_n", load_n,   1);
        check("t6_rdata",  rdata,    exp_rdata);
        check("t6_mem",    mem[9'h0AA], 8'h00);
        rdy_stuck = 1'b0;
        repeat (10) @(negedge clk);
        start_req(1'b0, 9'h055, 8'h00);
        check("t6_err_cleared", err, 0);
        wait_done(seen);
        check("t6_err_after", err, 0);
        check("t6_rdata_after", rdata, 8'h5A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
